// File: rtl/sync_fifo_pkg.sv
// Shared types, defaults and helpers for the synchronous FIFO controller family.
// Pointer wrap and flag decode live here so every FIFO variant computes them identically.
package sync_fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 8;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

    // Wraps by explicit compare so non-power-of-2 depths work.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

    function automatic fifo_flags_t flags_decode(input int unsigned cnt,
                                                 input int unsigned depth,
                                                 input int unsigned af_thresh,
                                                 input int unsigned ae_thresh);
        fifo_flags_t f;
        f.full         = (cnt == depth);
        f.empty        = (cnt == 32'd0);
        f.almost_full  = (cnt >= af_thresh);
        f.almost_empty = (cnt <= ae_thresh);
        return f;
    endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// Two-port storage array: one synchronous write port, one asynchronous read port.
// Reads of the address being written in the same cycle return the old word.
module fifo_mem_2p #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset; occupancy tracking guarantees stale words are never presented.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Parametrised synchronous FIFO with programmable almost flags, occupancy count,
// overflow/underflow pulses, arbitrary depth and selectable standard or FWFT read mode.
module sync_fifo_ctrl
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AF_THRESH = DEPTH - 1,
    parameter int AE_THRESH = 1,
    parameter int FWFT      = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       w_en,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       r_en,
    output logic [WIDTH-1:0]           data_out,
    output logic                       rd_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int         PTR_W = $clog2(DEPTH);
    localparam int         CNT_W = $clog2(DEPTH + 1);
    localparam fifo_mode_e MODE  = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

    if (WIDTH < 1) begin : g_chk_width
        $error("sync_fifo_ctrl: WIDTH must be >= 1");
    end
    if (DEPTH < 2) begin : g_chk_depth
        $error("sync_fifo_ctrl: DEPTH must be >= 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_chk_af
        $error("sync_fifo_ctrl: AF_THRESH must be in 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH >= AF_THRESH) begin : g_chk_ae
        $error("sync_fifo_ctrl: AE_THRESH must be in 0..AF_THRESH-1");
    end
    if (FWFT != 0 && FWFT != 1) begin : g_chk_fwft
        $error("sync_fifo_ctrl: FWFT must be 0 or 1");
    end

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] mem_rdata;
    logic             overflow_q;
    logic             underflow_q;
    logic             wr_ok;
    logic             rd_ok;
    fifo_flags_t      flags;

    assign flags = flags_decode(32'(count_q), DEPTH, AF_THRESH, AE_THRESH);

    // A full FIFO still accepts a write when a read frees the slot in the same cycle;
    // an empty FIFO never satisfies a read, even with a concurrent write.
    always_comb begin
        wr_ok = w_en & (~flags.full | r_en);
        rd_ok = r_en & ~flags.empty;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= PTR_W'(ptr_inc(32'(wr_ptr), DEPTH));
            end
            if (rd_ok) begin
                rd_ptr <= PTR_W'(ptr_inc(32'(rd_ptr), DEPTH));
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= w_en & ~wr_ok;
            underflow_q <= r_en & ~rd_ok;
        end
    end

    fifo_mem_2p #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wr_ptr),
        .wdata (data_in),
        .raddr (rd_ptr),
        .rdata (mem_rdata)
    );

    if (MODE == FIFO_STD) begin : g_std
        logic [WIDTH-1:0] dout_q;
        logic             rd_valid_q;

        // Registered read: sampling the array at the edge yields the old word on an address collision.
        always_ff @(posedge clk) begin
            if (rst) begin
                dout_q     <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_ok;
                if (rd_ok) begin
                    dout_q <= mem_rdata;
                end
            end
        end

        assign data_out = dout_q;
        assign rd_valid = rd_valid_q;
    end else begin : g_fwft
        assign data_out = flags.empty ? '0 : mem_rdata;
        assign rd_valid = ~flags.empty;
    end

    assign full         = flags.full;
    assign empty        = flags.empty;
    assign almost_full  = flags.almost_full;
    assign almost_empty = flags.almost_empty;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Drives three FIFO configurations (DEPTH 8 STD, DEPTH 5 STD, DEPTH 8 FWFT) with shared stimulus
// and compares each against a queue-based reference model.
module tb_sync_fifo_ctrl;

    localparam int NI = 3;
    localparam int M_DEPTH [NI] = '{8, 5, 8};
    localparam int M_AF    [NI] = '{6, 4, 6};
    localparam int M_AE    [NI] = '{1, 1, 1};
    localparam int M_FWFT  [NI] = '{0, 0, 1};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       w_en = 1'b0;
    logic       r_en = 1'b0;
    logic [7:0] data_in = '0;

    logic [7:0] dout [NI];
    logic       rv   [NI];
    logic       fl   [NI];
    logic       em   [NI];
    logic       af   [NI];
    logic       ae   [NI];
    logic       ov   [NI];
    logic       un   [NI];
    logic [3:0] cnt8;
    logic [2:0] cnt5;
    logic [3:0] cntf;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] mq [NI][$];
    logic [7:0] m_dout [NI];
    logic       m_rv [NI];
    logic       m_ov [NI];
    logic       m_un [NI];

    always #5 clk = ~clk;

    sync_fifo_ctrl #(.WIDTH(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(1), .FWFT(0)) u_d8 (
        .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .r_en(r_en),
        .data_out(dout[0]), .rd_valid(rv[0]), .full(fl[0]), .empty(em[0]),
        .almost_full(af[0]), .almost_empty(ae[0]), .count(cnt8),
        .overflow(ov[0]), .underflow(un[0])
    );

    sync_fifo_ctrl #(.WIDTH(8), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(1), .FWFT(0)) u_d5 (
        .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .r_en(r_en),
        .data_out(dout[1]), .rd_valid(rv[1]), .full(fl[1]), .empty(em[1]),
        .almost_full(af[1]), .almost_empty(ae[1]), .count(cnt5),
        .overflow(ov[1]), .underflow(un[1])
    );

    sync_fifo_ctrl #(.WIDTH(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(1), .FWFT(1)) u_f8 (
        .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .r_en(r_en),
        .data_out(dout[2]), .rd_valid(rv[2]), .full(fl[2]), .empty(em[2]),
        .almost_full(af[2]), .almost_empty(ae[2]), .count(cntf),
        .overflow(ov[2]), .underflow(un[2])
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference behaviour: accept rules on pre-edge occupancy, pop before push.
    task automatic model_update(input int i, input bit r, input bit w, input bit rd, input logic [7:0] d);
        int  n;
        bit  wr_ok;
        bit  rd_ok;
        logic [7:0] head;
        if (r) begin
            mq[i].delete();
            m_dout[i] = '0;
            m_rv[i]   = 1'b0;
            m_ov[i]   = 1'b0;
            m_un[i]   = 1'b0;
            return;
        end
        n     = mq[i].size();
        wr_ok = w && ((n != M_DEPTH[i]) || rd);
        rd_ok = rd && (n != 0);
        m_ov[i] = w && !wr_ok;
        m_un[i] = rd && !rd_ok;
        m_rv[i] = rd_ok;
        if (rd_ok) begin
            head = mq[i].pop_front();
            m_dout[i] = head;
        end
        if (wr_ok) mq[i].push_back(d);
    endtask

    task automatic check_inst(input int i);
        int n;
        int c;
        logic [7:0] exp_d;
        logic       exp_v;
        n = mq[i].size();
        c = (i == 0) ? int'(cnt8) : (i == 1) ? int'(cnt5) : int'(cntf);
        if (M_FWFT[i] != 0) begin
            exp_d = (n != 0) ? mq[i][0] : 8'h00;
            exp_v = (n != 0);
        end else begin
            exp_d = m_dout[i];
            exp_v = m_rv[i];
        end
        check($sformatf("u%0d.count", i),        32'(c),              32'(n));
        check($sformatf("u%0d.empty", i),        32'(em[i]),          32'(n == 0));
        check($sformatf("u%0d.full", i),         32'(fl[i]),          32'(n == M_DEPTH[i]));
        check($sformatf("u%0d.almost_full", i),  32'(af[i]),          32'(n >= M_AF[i]));
        check($sformatf("u%0d.almost_empty", i), 32'(ae[i]),          32'(n <= M_AE[i]));
        check($sformatf("u%0d.overflow", i),     32'(ov[i]),          32'(m_ov[i]));
        check($sformatf("u%0d.underflow", i),    32'(un[i]),          32'(m_un[i]));
        check($sformatf("u%0d.rd_valid", i),     32'(rv[i]),          32'(exp_v));
        check($sformatf("u%0d.data_out", i),     32'(dout[i]),        32'(exp_d));
    endtask

    task automatic step(input bit r, input bit w, input bit rd, input logic [7:0] d);
        @(negedge clk);
        rst     = r;
        w_en    = w;
        r_en    = rd;
        data_in = d;
        @(posedge clk);
        for (int i = 0; i < NI; i++) model_update(i, r, w, rd, d);
        #1;
        for (int i = 0; i < NI; i++) check_inst(i);
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            m_dout[i] = '0;
            m_rv[i]   = 1'b0;
            m_ov[i]   = 1'b0;
            m_un[i]   = 1'b0;
        end

        // Reset held two cycles with a write pending: nothing may be stored.
        step(1'b1, 1'b1, 1'b0, 8'h55);
        step(1'b1, 1'b1, 1'b0, 8'h66);
        step(1'b0, 1'b0, 1'b0, 8'h00);

        // Fill past capacity, then drain past empty.
        for (int k = 1; k <= 9; k++) step(1'b0, 1'b1, 1'b0, 8'(k));
        for (int k = 0; k < 9; k++)  step(1'b0, 1'b0, 1'b1, 8'h00);

        // Write+read while full.
        for (int k = 1; k <= 8; k++) step(1'b0, 1'b1, 1'b0, 8'(k));
        step(1'b0, 1'b1, 1'b1, 8'hAA);
        for (int k = 0; k < 9; k++)  step(1'b0, 1'b0, 1'b1, 8'h00);

        // Repeated fill/drain of 5 wraps the pointers of the non-power-of-2 instance.
        for (int round = 0; round < 3; round++) begin
            for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b0, 8'($urandom_range(0, 255)));
            for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b1, 8'h00);
        end

        // First-word fall-through visibility and pop; write+read into empty.
        step(1'b0, 1'b1, 1'b0, 8'h3C);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 1'b1, 8'h5A);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);

        // Reset in the middle of traffic, then confirm fresh ordering.
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b0, 8'(8'h40 + k));
        step(1'b1, 1'b1, 1'b1, 8'h77);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 8'(8'h90 + k));
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b1, 8'h00);

        // Random traffic with slowly drifting write/read bias so both full and empty are visited.
        for (int k = 0; k < 3000; k++) begin
            int  wp;
            bit  r;
            bit  w;
            bit  rd;
            wp = ((k / 100) % 2 == 0) ? 70 : 30;
            r  = ($urandom_range(0, 299) == 0);
            w  = ($urandom_range(0, 99) < wp);
            rd = ($urandom_range(0, 99) < (100 - wp));
            step(r, w, rd, 8'($urandom_range(0, 255)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
